// File: rtl/mul_share_ctrl_if.sv
// rtl/mul_share_ctrl_if.sv - requester and multiplier signal bundle for mul_share_ctrl
interface mul_share_ctrl_if #(
    parameter int NREQ = 4
);
    logic [NREQ-1:0]    req;
    logic [NREQ*32-1:0] req_a;
    logic [NREQ*32-1:0] req_b;
    logic [NREQ-1:0]    done;
    logic [63:0]        rsp_result;
    logic               rsp_err;
    logic               busy;
    logic               mul_start;
    logic               mul_muordi;
    logic [31:0]        mul_opera1;
    logic [63:0]        mul_opera2;
    logic               mul_valid;
    logic [63:0]        mul_result;

    modport slave (
        input  req, req_a, req_b, mul_valid, mul_result,
        output done, rsp_result, rsp_err, busy, mul_start, mul_muordi, mul_opera1, mul_opera2
    );

    modport master (
        output req, req_a, req_b, mul_valid, mul_result,
        input  done, rsp_result, rsp_err, busy, mul_start, mul_muordi, mul_opera1, mul_opera2
    );
endinterface

// File: rtl/mul_share_ctrl.sv
// rtl/mul_share_ctrl.sv - round-robin sharing of one signed 32x32 multiplier among NREQ requesters
// Optional RUN watchdog enabled by defining MUL_TIMEOUT_EN.
module mul_share_ctrl #(
    parameter int NREQ      = 4,
    parameter int START_CYC = 2,
    parameter int TIMEOUT   = 256
) (
    input  logic            clock,
    input  logic            reset,
    mul_share_ctrl_if.slave bus
);
    localparam int IDW = $clog2(NREQ);
    localparam int SCW = $clog2(START_CYC + 1);

    if (NREQ < 2 || NREQ > 8 || START_CYC < 2 || TIMEOUT < 1) begin : g_bad_param
        $error("mul_share_ctrl: parameter out of range");
    end

    typedef enum logic [2:0] {S_IDLE, S_ARB, S_LAUNCH, S_RUN, S_DONE} state_t;

    state_t         state, state_nx;
    logic [IDW-1:0] rr_ptr, grant_id, pick_id;
    logic           pick_ok;
    logic [IDW:0]   j_sum;
    logic [31:0]    pick_a, pick_b;
    logic [31:0]    op_a, op_b;
    logic [SCW-1:0] start_cnt;
    logic           launch_last;
    logic           run_seen;
    logic           run_hit, run_abort;
    logic [63:0]    rsp_result_q;
    logic           rsp_err_q;

    // Search upward from rr_ptr; iterating downward lets the nearest set bit win.
    always_comb begin
        pick_id = '0;
        pick_ok = 1'b0;
        j_sum   = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            j_sum = {1'b0, rr_ptr} + (IDW + 1)'(k);
            if (j_sum >= (IDW + 1)'(NREQ))
                j_sum = j_sum - (IDW + 1)'(NREQ);
            if (bus.req[j_sum[IDW-1:0]]) begin
                pick_id = j_sum[IDW-1:0];
                pick_ok = 1'b1;
            end
        end
    end

    always_comb begin
        pick_a = '0;
        pick_b = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (pick_id == IDW'(i)) begin
                pick_a = bus.req_a[32*i +: 32];
                pick_b = bus.req_b[32*i +: 32];
            end
        end
    end

    assign launch_last = (start_cnt == SCW'(START_CYC - 1));
    // The multiplier only clears valid while start is high, so the first RUN cycle may see a stale level.
    assign run_hit     = run_seen && bus.mul_valid;

`ifdef MUL_TIMEOUT_EN
    localparam int TCW = $clog2(TIMEOUT) + 1;
    logic [TCW-1:0] run_cnt;

    assign run_abort = (run_cnt == TCW'(TIMEOUT - 1)) && !run_hit;

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            run_cnt <= '0;
        else if (state == S_LAUNCH)
            run_cnt <= '0;
        else if (state == S_RUN)
            run_cnt <= run_cnt + 1'b1;
    end
`else
    assign run_abort = 1'b0;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            state <= S_IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx      = state;
        bus.mul_start = 1'b1;
        bus.busy      = 1'b1;
        bus.done      = '0;
        case (state)
            S_IDLE: begin
                bus.busy = 1'b0;
                if (|bus.req)
                    state_nx = S_ARB;
            end
            S_ARB:    state_nx = pick_ok ? S_LAUNCH : S_IDLE;
            S_LAUNCH: if (launch_last) state_nx = S_RUN;
            S_RUN: begin
                bus.mul_start = 1'b0;
                if (run_hit || run_abort)
                    state_nx = S_DONE;
            end
            S_DONE: begin
                state_nx = S_IDLE;
                for (int i = 0; i < NREQ; i++)
                    bus.done[i] = (grant_id == IDW'(i));
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rr_ptr       <= '0;
            grant_id     <= '0;
            op_a         <= '0;
            op_b         <= '0;
            start_cnt    <= '0;
            run_seen     <= 1'b0;
            rsp_result_q <= '0;
            rsp_err_q    <= 1'b0;
        end else begin
            if (state == S_ARB && pick_ok) begin
                grant_id <= pick_id;
                op_a     <= pick_a;
                op_b     <= pick_b;
                rr_ptr   <= (pick_id == IDW'(NREQ - 1)) ? '0 : pick_id + 1'b1;
            end
            start_cnt <= (state == S_LAUNCH) ? start_cnt + 1'b1 : '0;
            run_seen  <= (state == S_RUN);
            if (state == S_RUN && run_hit) begin
                rsp_result_q <= bus.mul_result;
                rsp_err_q    <= 1'b0;
            end else if (state == S_RUN && run_abort) begin
                rsp_result_q <= '0;
                rsp_err_q    <= 1'b1;
            end
        end
    end

    assign bus.rsp_result = rsp_result_q;
    assign bus.rsp_err    = rsp_err_q;
    assign bus.mul_muordi = 1'b0;
    assign bus.mul_opera1 = op_a;
    assign bus.mul_opera2 = {32'b0, op_b};
endmodule

// File: tb/tb_mul_share_ctrl.sv
// tb/tb_mul_share_ctrl.sv - self-checking bench for mul_share_ctrl with a behavioural multiplier
`timescale 1ns/1ps
module tb_mul_share_ctrl;
    localparam int NREQ      = 4;
    localparam int START_CYC = 2;
`ifdef MUL_TIMEOUT_EN
    localparam int TIMEOUT   = 16;
`else
    localparam int TIMEOUT   = 256;
`endif

    logic clock = 1'b0;
    logic reset = 1'b1;

    mul_share_ctrl_if #(.NREQ(NREQ)) bus();

    mul_share_ctrl #(.NREQ(NREQ), .START_CYC(START_CYC), .TIMEOUT(TIMEOUT)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_bad = 0;

    function automatic logic [63:0] smul(input logic [31:0] a, input logic [31:0] b);
        longint x, y;
        x = longint'($signed(a));
        y = longint'($signed(b));
        return 64'(x * y);
    endfunction

    // Behavioural multiplier: start clears valid; after mm_lat start-low cycles valid rises.
    logic        mm_valid    = 1'b0;
    logic [63:0] mm_result   = '0;
    int          mm_cnt      = 0;
    int          mm_lat      = 2;
    bit          mm_hold     = 1'b0;
    logic        valid_force = 1'b0;

    always @(posedge clock) begin
        if (bus.mul_start) begin
            mm_valid <= 1'b0;
            mm_cnt   <= mm_lat;
        end else if (!mm_hold) begin
            if (mm_cnt == 0) begin
                mm_valid  <= 1'b1;
                mm_result <= smul(bus.mul_opera1, bus.mul_opera2[31:0]);
            end else begin
                mm_cnt <= mm_cnt - 1;
            end
        end
    end

    assign bus.mul_valid  = mm_valid | valid_force;
    assign bus.mul_result = mm_result;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic wait_done(input int budget, output logic [NREQ-1:0] d);
        int c;
        d = '0;
        c = 0;
        while (d == '0 && c < budget) begin
            tick();
            c++;
            d = bus.done;
        end
        if (d == '0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL done_wait: no done within %0d cycles", budget);
        end
    endtask

    task automatic wait_run(input int budget);
        int c;
        c = 0;
        while (bus.mul_start !== 1'b0 && c < budget) begin
            tick();
            c++;
        end
        if (bus.mul_start !== 1'b0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL run_wait: mul_start still high after %0d cycles", budget);
        end
    endtask

    task automatic set_op(input int idx, input logic [31:0] a, input logic [31:0] b);
        bus.req_a[32*idx +: 32] = a;
        bus.req_b[32*idx +: 32] = b;
    endtask

    task automatic pulse_reset();
        @(negedge clock);
        reset = 1'b1;
        bus.req = '0;
        tick();
        tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic run_one(input int idx, input logic [31:0] a, input logic [31:0] b,
                           input logic [63:0] exp, input string name);
        logic [NREQ-1:0] d;
        set_op(idx, a, b);
        bus.req[idx] = 1'b1;
        wait_done(200, d);
        bus.req[idx] = 1'b0;
        chk({name, "_done"}, 64'(d), 64'(1) << idx);
        chk({name, "_res"}, bus.rsp_result, exp);
        chk({name, "_err"}, 64'(bus.rsp_err), 64'd0);
        tick();
    endtask

    typedef struct {
        int          idx;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] exp;
    } vec_t;

    vec_t vt[6];

    initial begin
        logic [NREQ-1:0] d;
        logic [31:0]     ra[NREQ];
        logic [31:0]     rb[NREQ];
        bit              pend[NREQ];
        int              ptr, win, cyc, cnt, busy_cnt;

        vt[0] = '{0, 32'd7,        32'hFFFFFFFD, 64'hFFFFFFFFFFFFFFEB};
        vt[1] = '{1, 32'hFFFFFFFB, 32'hFFFFFFFA, 64'd30};
        vt[2] = '{2, 32'h80000000, 32'd1,        64'hFFFFFFFF80000000};
        vt[3] = '{3, 32'd0,        32'hFFFFFFFF, 64'd0};
        vt[4] = '{0, 32'h7FFFFFFF, 32'h7FFFFFFF, 64'h3FFFFFFF00000001};
        vt[5] = '{1, 32'h80000000, 32'h80000000, 64'h4000000000000000};

        bus.req   = '0;
        bus.req_a = '0;
        bus.req_b = '0;

        // Reset state
        #12;
        chk("rst_done",   64'(bus.done), 64'd0);
        chk("rst_busy",   64'(bus.busy), 64'd0);
        chk("rst_start",  64'(bus.mul_start), 64'd1);
        chk("rst_result", bus.rsp_result, 64'd0);
        chk("rst_err",    64'(bus.rsp_err), 64'd0);
        chk("rst_opera1", 64'(bus.mul_opera1), 64'd0);
        chk("rst_opera2", bus.mul_opera2, 64'd0);
        chk("rst_muordi", 64'(bus.mul_muordi), 64'd0);
        @(negedge clock);
        reset = 1'b0;
        tick();

        // Latency: req to mul_start falling, and done one cycle after valid rises
        set_op(0, 32'd7, 32'hFFFFFFFD);
        bus.req[0] = 1'b1;
        cyc = 0;
        while (bus.mul_start !== 1'b0 && cyc < 20) begin
            tick();
            cyc++;
        end
        chk("lat_start_fall", 64'(cyc), 64'(2 + START_CYC));
        chk("lat_opera1", 64'(bus.mul_opera1), 64'd7);
        chk("lat_opera2", bus.mul_opera2, 64'h00000000FFFFFFFD);
        cyc = 0;
        while (bus.mul_valid !== 1'b1 && cyc < 20) begin
            tick();
            cyc++;
        end
        chk("lat_valid_seen", 64'(bus.mul_valid), 64'd1);
        chk("lat_no_early_done", 64'(bus.done), 64'd0);
        tick();
        chk("lat_done", 64'(bus.done), 64'b0001);
        chk("lat_result", bus.rsp_result, 64'hFFFFFFFFFFFFFFEB);
        bus.req[0] = 1'b0;
        tick();
        chk("lat_done_one_cycle", 64'(bus.done), 64'd0);
        chk("lat_idle", 64'(bus.busy), 64'd0);

        // Table of single operations
        for (int i = 0; i < 6; i++)
            run_one(vt[i].idx, vt[i].a, vt[i].b, vt[i].exp, $sformatf("vec%0d", i));

        // mul_valid while idle is ignored
        valid_force = 1'b1;
        cnt = 0;
        busy_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (bus.done != '0) cnt++;
            if (bus.busy) busy_cnt++;
        end
        valid_force = 1'b0;
        chk("idle_valid_done", 64'(cnt), 64'd0);
        chk("idle_valid_busy", 64'(busy_cnt), 64'd0);
        tick();

        // Round robin from a fresh pointer with every requester held
        pulse_reset();
        for (int i = 0; i < NREQ; i++) set_op(i, 32'(i * 1000 + 11), 32'(-(i + 3)));
        bus.req = '1;
        for (int g = 0; g < 8; g++) begin
            wait_done(200, d);
            chk($sformatf("rr_order%0d", g), 64'(d), 64'(1) << (g % NREQ));
            chk($sformatf("rr_res%0d", g), bus.rsp_result,
                smul(32'((g % NREQ) * 1000 + 11), 32'(-((g % NREQ) + 3))));
            if (g == 7) bus.req = '0;
        end
        tick();

        // req[2] dropped during RUN: done still pulses with latched operands
        set_op(2, 32'd123, 32'hFFFFFFFC);
        bus.req[2] = 1'b1;
        wait_run(20);
        bus.req[2] = 1'b0;
        set_op(2, 32'd999, 32'd999);
        wait_done(200, d);
        chk("drop_done", 64'(d), 64'b0100);
        chk("drop_res", bus.rsp_result, 64'hFFFFFFFFFFFFFE14);
        tick();

        // req[1] rises during DONE of index 0 and wins over re-asserted 0
        set_op(0, 32'd2, 32'd3);
        bus.req[0] = 1'b1;
        wait_done(200, d);
        chk("rejoin_first", 64'(d), 64'b0001);
        set_op(1, 32'd4, 32'd5);
        bus.req[1] = 1'b1;
        wait_done(200, d);
        chk("rejoin_second", 64'(d), 64'b0010);
        chk("rejoin_second_res", bus.rsp_result, 64'd20);
        bus.req[1] = 1'b0;
        wait_done(200, d);
        chk("rejoin_third", 64'(d), 64'b0001);
        chk("rejoin_third_res", bus.rsp_result, 64'd6);
        bus.req[0] = 1'b0;
        tick();

        // Reset during RUN
        mm_hold = 1'b1;
        set_op(3, 32'd50, 32'd60);
        bus.req[3] = 1'b1;
        wait_run(20);
        tick();
        reset = 1'b1;
        #1;
        chk("mid_rst_done",   64'(bus.done), 64'd0);
        chk("mid_rst_busy",   64'(bus.busy), 64'd0);
        chk("mid_rst_start",  64'(bus.mul_start), 64'd1);
        chk("mid_rst_result", bus.rsp_result, 64'd0);
        chk("mid_rst_opera1", 64'(bus.mul_opera1), 64'd0);
        bus.req = '0;
        mm_hold = 1'b0;
        cnt = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (bus.done != '0) cnt++;
        end
        reset = 1'b0;
        tick();
        chk("mid_rst_no_done", 64'(cnt), 64'd0);
        run_one(2, 32'hFFFFFF9C, 32'd77, 64'hFFFFFFFFFFFFE1EC, "post_rst");

        // Randomized traffic against a pointer-based arbitration model
        pulse_reset();
        ptr = 0;
        for (int i = 0; i < NREQ; i++) begin
            pend[i] = ($urandom_range(0, 1) == 1);
            ra[i] = $urandom;
            rb[i] = $urandom;
            set_op(i, ra[i], rb[i]);
        end
        if (!pend[0] && !pend[1] && !pend[2] && !pend[3]) pend[$urandom_range(0, NREQ - 1)] = 1'b1;
        for (int i = 0; i < NREQ; i++) bus.req[i] = pend[i];
        for (int n = 0; n < 60; n++) begin
            mm_lat = $urandom_range(0, 5);
            wait_done(300, d);
            win = -1;
            for (int k = 0; k < NREQ; k++)
                if (win < 0 && pend[(ptr + k) % NREQ]) win = (ptr + k) % NREQ;
            chk($sformatf("rand%0d_grant", n), 64'(d), 64'(1) << win);
            chk($sformatf("rand%0d_res", n), bus.rsp_result, smul(ra[win], rb[win]));
            pend[win] = 1'b0;
            bus.req[win] = 1'b0;
            ptr = (win + 1) % NREQ;
            cnt = 0;
            for (int i = 0; i < NREQ; i++) begin
                if (!pend[i] && $urandom_range(0, 2) == 0) begin
                    ra[i] = $urandom;
                    rb[i] = $urandom;
                    set_op(i, ra[i], rb[i]);
                    pend[i] = 1'b1;
                    bus.req[i] = 1'b1;
                end
                if (pend[i]) cnt++;
            end
            if (cnt == 0) begin
                ra[win] = $urandom;
                rb[win] = $urandom;
                set_op(win, ra[win], rb[win]);
                pend[win] = 1'b1;
                bus.req[win] = 1'b1;
            end
        end
        bus.req = '0;
        tick();
        tick();
        chk("rand_end_idle", 64'(bus.busy), 64'd0);

`ifdef MUL_TIMEOUT_EN
        // Watchdog abort with valid never arriving
        mm_hold = 1'b1;
        set_op(0, 32'd9, 32'd9);
        bus.req[0] = 1'b1;
        d = '0;
        cyc = 0;
        cnt = 0;
        while (d == '0 && cyc < 200) begin
            tick();
            cyc++;
            if (bus.mul_start === 1'b0) cnt++;
            d = bus.done;
        end
        bus.req[0] = 1'b0;
        chk("wd_done", 64'(d), 64'b0001);
        chk("wd_run_cycles", 64'(cnt), 64'(TIMEOUT));
        chk("wd_err", 64'(bus.rsp_err), 64'd1);
        chk("wd_res", bus.rsp_result, 64'd0);
        chk("wd_start", 64'(bus.mul_start), 64'd1);
        tick();
        chk("wd_idle", 64'(bus.busy), 64'd0);
        mm_hold = 1'b0;
        tick();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
